// File: rtl/gfx_pkg.sv
// Shared constants for the tile scroll sequencer: FSM encodings, peripheral
// register addresses and default tilemap geometry.
package gfx_pkg;

  typedef logic [1:0] scroll_state_t;

  localparam scroll_state_t ST_IDLE  = 2'd0;
  localparam scroll_state_t ST_WR_LO = 2'd1;
  localparam scroll_state_t ST_WR_HI = 2'd2;
  localparam scroll_state_t ST_FILL  = 2'd3;

  localparam logic [14:0] SCROLL_ADDR  = 15'h3000;
  localparam logic [14:0] TILEMAP_BASE = 15'h0000;
  localparam logic [14:0] TILEMAP_SIZE = 15'h1000;

  localparam int DEF_MAP_COLS    = 128;
  localparam int DEF_MAP_ROWS    = 30;
  localparam int DEF_TILE_W_LOG2 = 3;
  localparam int DEF_LEAD_COLS   = 81;

endpackage

// File: rtl/tile_scroll_ctrl_if.sv
// Avalon-MM style byte bus used on both the host side and the peripheral side.
interface tile_scroll_ctrl_if;
  logic        chipselect;
  logic        write;
  logic [14:0] address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        waitrequest;

  modport master (output chipselect, write, address, writedata,
                  input  readdata, waitrequest);
  modport slave  (input  chipselect, write, address, writedata,
                  output readdata, waitrequest);
endinterface

// File: rtl/avalon_bus_mux.sv
// Two-way bus arbiter: the host passes straight through unless the controller
// owns the bus, in which case host requests are stalled.
module avalon_bus_mux (
  input  logic               i_sel_ctrl,
  tile_scroll_ctrl_if.slave  host,
  input  logic               i_ctrl_chipselect,
  input  logic               i_ctrl_write,
  input  logic [14:0]        i_ctrl_address,
  input  logic [7:0]         i_ctrl_writedata,
  tile_scroll_ctrl_if.master m
);

  always_comb begin
    host.readdata = m.readdata;
    if (i_sel_ctrl) begin
      m.chipselect     = i_ctrl_chipselect;
      m.write          = i_ctrl_write;
      m.address        = i_ctrl_address;
      m.writedata      = i_ctrl_writedata;
      host.waitrequest = host.chipselect;
    end else begin
      m.chipselect     = host.chipselect;
      m.write          = host.write;
      m.address        = host.address;
      m.writedata      = host.writedata;
      host.waitrequest = 1'b0;
    end
  end

endmodule

// File: rtl/tile_scroll_ctrl.sv
// Per-frame scroll sequencer: writes the new pixel offset to the peripheral and
// refills one off-screen tilemap column whenever a tile boundary is crossed.
//
//   state    | meaning
//   ST_IDLE  | host owns the bus, waiting for an enabled frame tick
//   ST_WR_LO | writing scroll offset low byte
//   ST_WR_HI | writing scroll offset high byte, committing the offset
//   ST_FILL  | streaming MAP_ROWS tile bytes into the lead column
module tile_scroll_ctrl
  import gfx_pkg::*;
#(
  parameter int MAP_COLS    = DEF_MAP_COLS,
  parameter int MAP_ROWS    = DEF_MAP_ROWS,
  parameter int TILE_W_LOG2 = DEF_TILE_W_LOG2,
  parameter int LEAD_COLS   = DEF_LEAD_COLS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [2:0]         speed,
  tile_scroll_ctrl_if.slave  host,
  input  logic               col_valid,
  input  logic [7:0]         col_data,
  output logic               col_ready,
  tile_scroll_ctrl_if.master m,
  output logic [9:0]         scroll_offset,
  output logic               busy,
  output logic               underrun
);

  localparam int COL_W = $clog2(MAP_COLS);
  localparam int ROW_W = $clog2(MAP_ROWS);

  scroll_state_t    r_state;
  logic [9:0]       r_scroll;
  logic [9:0]       r_new;
  logic             r_crossed;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_fill_col;
  logic             r_underrun;

  logic [9:0]  w_sum;
  logic        w_crossed;
  logic        w_last_row;
  logic        w_busy;
  logic [14:0] w_fill_addr;
  logic        w_ctrl_cs;
  logic        w_ctrl_we;
  logic [14:0] w_ctrl_addr;
  logic [7:0]  w_ctrl_wdata;

  assign w_sum       = r_scroll + {7'd0, speed};
  assign w_crossed   = (w_sum >> TILE_W_LOG2) != (r_scroll >> TILE_W_LOG2);
  assign w_last_row  = (r_row == ROW_W'(MAP_ROWS - 1));
  assign w_busy      = (r_state != ST_IDLE);
  assign w_fill_addr = TILEMAP_BASE + ((15'(r_row) << COL_W) | 15'(r_fill_col));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_scroll   <= '0;
      r_new      <= '0;
      r_crossed  <= 1'b0;
      r_row      <= '0;
      r_fill_col <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (frame_tick && w_busy)
        r_underrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (frame_tick && enable) begin
            r_new     <= w_sum;
            r_crossed <= w_crossed;
            r_state   <= ST_WR_LO;
          end
        end
        ST_WR_LO: r_state <= ST_WR_HI;
        ST_WR_HI: begin
          r_scroll <= r_new;
          if (r_crossed) begin
            // lead column wraps naturally through the COL_W-bit truncation
            r_fill_col <= COL_W'(r_new >> TILE_W_LOG2) + COL_W'(LEAD_COLS);
            r_row      <= '0;
            r_state    <= ST_FILL;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (col_valid) begin
            r_row <= r_row + ROW_W'(1);
            if (w_last_row)
              r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ctrl_cs    = 1'b0;
    w_ctrl_we    = 1'b0;
    w_ctrl_addr  = '0;
    w_ctrl_wdata = '0;
    col_ready    = 1'b0;
    case (r_state)
      ST_WR_LO: begin
        w_ctrl_cs    = 1'b1;
        w_ctrl_we    = 1'b1;
        w_ctrl_addr  = SCROLL_ADDR;
        w_ctrl_wdata = r_new[7:0];
      end
      ST_WR_HI: begin
        w_ctrl_cs    = 1'b1;
        w_ctrl_we    = 1'b1;
        w_ctrl_addr  = SCROLL_ADDR + 15'd1;
        w_ctrl_wdata = {6'd0, r_new[9:8]};
      end
      ST_FILL: begin
        w_ctrl_cs    = col_valid;
        w_ctrl_we    = col_valid;
        w_ctrl_addr  = w_fill_addr;
        w_ctrl_wdata = col_data;
        col_ready    = col_valid;
      end
      default: ;
    endcase
  end

  avalon_bus_mux u_bus_mux (
    .i_sel_ctrl        (w_busy),
    .host              (host),
    .i_ctrl_chipselect (w_ctrl_cs),
    .i_ctrl_write      (w_ctrl_we),
    .i_ctrl_address    (w_ctrl_addr),
    .i_ctrl_writedata  (w_ctrl_wdata),
    .m                 (m)
  );

  assign scroll_offset = r_scroll;
  assign busy          = w_busy;
  assign underrun      = r_underrun;

endmodule

// File: tb/tb_tile_scroll_ctrl.sv
// Directed bench for tile_scroll_ctrl with hand-computed expected bus traffic.
module tb_tile_scroll_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       enable;
  logic [2:0] speed;
  logic       col_valid;
  logic [7:0] col_data;
  logic       col_ready;
  logic [9:0] scroll_offset;
  logic       busy;
  logic       underrun;

  tile_scroll_ctrl_if host_bus ();
  tile_scroll_ctrl_if m_bus ();

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tile_scroll_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .enable        (enable),
    .speed         (speed),
    .host          (host_bus.slave),
    .col_valid     (col_valid),
    .col_data      (col_data),
    .col_ready     (col_ready),
    .m             (m_bus.master),
    .scroll_offset (scroll_offset),
    .busy          (busy),
    .underrun      (underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // one enabled tick, then feed tile bytes until the controller releases the bus
  task automatic run_frame(input logic [2:0] spd);
    int guard;
    next_cycle;
    frame_tick = 1'b1;
    enable     = 1'b1;
    speed      = spd;
    next_cycle;
    frame_tick = 1'b0;
    col_valid  = 1'b1;
    col_data   = 8'h00;
    #1;
    guard = 0;
    while (busy && guard < 100) begin
      next_cycle;
      #1;
      guard++;
    end
    col_valid = 1'b0;
    chk("frame_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int  row;
    int  stall;
    int  pulses;
    bit  ticked;

    reset                = 1'b1;
    frame_tick           = 1'b0;
    enable               = 1'b0;
    speed                = 3'd0;
    col_valid            = 1'b0;
    col_data             = 8'h00;
    host_bus.chipselect  = 1'b1;
    host_bus.write       = 1'b1;
    host_bus.address     = 15'h0123;
    host_bus.writedata   = 8'h3C;
    m_bus.readdata       = 8'h00;
    m_bus.waitrequest    = 1'b0;

    repeat (3) next_cycle;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_scroll", {22'd0, scroll_offset}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_col_ready", {31'd0, col_ready}, 32'd0);
    chk("rst_waitreq", {31'd0, host_bus.waitrequest}, 32'd0);
    chk("rst_pass_addr", {17'd0, m_bus.address}, 32'h0123);
    chk("rst_pass_data", {24'd0, m_bus.writedata}, 32'h3C);
    reset = 1'b0;
    host_bus.chipselect = 1'b0;

    // speed 3 from 0: scroll writes only
    next_cycle;
    frame_tick = 1'b1;
    enable     = 1'b1;
    speed      = 3'd3;
    next_cycle;
    frame_tick = 1'b0;
    #1;
    chk("t1_lo_cs", {31'd0, m_bus.chipselect}, 32'd1);
    chk("t1_lo_we", {31'd0, m_bus.write}, 32'd1);
    chk("t1_lo_addr", {17'd0, m_bus.address}, 32'h3000);
    chk("t1_lo_data", {24'd0, m_bus.writedata}, 32'h03);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    next_cycle;
    #1;
    chk("t1_hi_addr", {17'd0, m_bus.address}, 32'h3001);
    chk("t1_hi_data", {24'd0, m_bus.writedata}, 32'h00);
    next_cycle;
    #1;
    chk("t1_idle", {31'd0, busy}, 32'd0);
    chk("t1_scroll", {22'd0, scroll_offset}, 32'd3);

    // tick with enable low is ignored
    next_cycle;
    frame_tick = 1'b1;
    enable     = 1'b0;
    next_cycle;
    frame_tick = 1'b0;
    enable     = 1'b1;
    #1;
    chk("dis_busy", {31'd0, busy}, 32'd0);
    chk("dis_scroll", {22'd0, scroll_offset}, 32'd3);

    run_frame(3'd3);
    chk("t2_pre_scroll", {22'd0, scroll_offset}, 32'd6);

    // 6 + 3 = 9 crosses into tile 1, lead column 82
    next_cycle;
    frame_tick = 1'b1;
    speed      = 3'd3;
    next_cycle;
    frame_tick = 1'b0;
    #1;
    chk("t2_lo_data", {24'd0, m_bus.writedata}, 32'h09);
    next_cycle;
    #1;
    chk("t2_hi_addr", {17'd0, m_bus.address}, 32'h3001);

    row = 0; stall = 0; pulses = 0; ticked = 1'b0;
    for (int c = 0; c < 200 && row < 30; c++) begin
      next_cycle;
      col_valid  = !(row == 10 && stall < 5);
      col_data   = 8'(row);
      frame_tick = (row == 5) && !ticked;
      if (frame_tick) ticked = 1'b1;
      if (row == 3) begin
        host_bus.chipselect = 1'b1;
        host_bus.write      = 1'b1;
        host_bus.address    = 15'h0005;
        host_bus.writedata  = 8'h5A;
      end
      #1;
      chk("fill_busy", {31'd0, busy}, 32'd1);
      if (col_ready) pulses++;
      if (host_bus.chipselect)
        chk("fill_waitreq", {31'd0, host_bus.waitrequest}, 32'd1);
      if (col_valid) begin
        chk("fill_cs", {31'd0, m_bus.chipselect}, 32'd1);
        chk("fill_addr", {17'd0, m_bus.address}, 32'(row * 128 + 82));
        chk("fill_data", {24'd0, m_bus.writedata}, 32'(row));
        row++;
      end else begin
        chk("stall_cs", {31'd0, m_bus.chipselect}, 32'd0);
        chk("stall_ready", {31'd0, col_ready}, 32'd0);
        stall++;
      end
    end
    chk("fill_rows", 32'(row), 32'd30);
    chk("fill_pulses", 32'(pulses), 32'd30);

    next_cycle;
    frame_tick = 1'b0;
    col_valid  = 1'b0;
    #1;
    chk("host_release_busy", {31'd0, busy}, 32'd0);
    chk("host_release_wait", {31'd0, host_bus.waitrequest}, 32'd0);
    chk("host_release_cs", {31'd0, m_bus.chipselect}, 32'd1);
    chk("host_release_addr", {17'd0, m_bus.address}, 32'h0005);
    chk("host_release_data", {24'd0, m_bus.writedata}, 32'h5A);
    chk("t2_scroll", {22'd0, scroll_offset}, 32'd9);
    chk("t2_underrun", {31'd0, underrun}, 32'd1);
    host_bus.chipselect = 1'b0;

    // advance 9 -> 1020, then wrap with speed 7 to 3
    for (int f = 0; f < 144; f++) run_frame(3'd7);
    run_frame(3'd3);
    chk("t3_pre_scroll", {22'd0, scroll_offset}, 32'd1020);
    chk("t3_underrun_sticky", {31'd0, underrun}, 32'd1);

    next_cycle;
    frame_tick = 1'b1;
    speed      = 3'd7;
    next_cycle;
    frame_tick = 1'b0;
    #1;
    chk("t3_lo_addr", {17'd0, m_bus.address}, 32'h3000);
    chk("t3_lo_data", {24'd0, m_bus.writedata}, 32'h03);
    next_cycle;
    #1;
    chk("t3_hi_data", {24'd0, m_bus.writedata}, 32'h00);
    next_cycle;
    col_valid = 1'b1;
    col_data  = 8'h77;
    #1;
    chk("t3_scroll", {22'd0, scroll_offset}, 32'd3);
    chk("t3_fill_addr0", {17'd0, m_bus.address}, 32'd81);
    chk("t3_fill_data0", {24'd0, m_bus.writedata}, 32'h77);
    next_cycle;
    #1;
    chk("t3_fill_addr1", {17'd0, m_bus.address}, 32'd209);

    // asynchronous reset mid-column
    next_cycle;
    col_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_underrun", {31'd0, underrun}, 32'd0);
    chk("arst_scroll", {22'd0, scroll_offset}, 32'd0);
    chk("arst_cs", {31'd0, m_bus.chipselect}, 32'd0);
    next_cycle;
    reset = 1'b0;

    // host read in idle
    next_cycle;
    m_bus.readdata      = 8'hA5;
    host_bus.chipselect = 1'b1;
    host_bus.write      = 1'b0;
    host_bus.address    = 15'h1234;
    #1;
    chk("rd_data", {24'd0, host_bus.readdata}, 32'hA5);
    chk("rd_cs", {31'd0, m_bus.chipselect}, 32'd1);
    chk("rd_we", {31'd0, m_bus.write}, 32'd0);
    chk("rd_addr", {17'd0, m_bus.address}, 32'h1234);
    chk("rd_wait", {31'd0, host_bus.waitrequest}, 32'd0);
    host_bus.chipselect = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_scroll_ctrl.md
Name: tile_scroll_ctrl

Overview:
Hardware scroll sequencer and bus arbiter placed between the HPS Avalon bridge and the VGA tile peripheral. On each frame tick it advances the 10-bit pixel scroll offset by a programmable speed and writes the result into the peripheral's scroll register. When the scroll crosses a tile-column boundary, it streams one new tilemap column from a column source into the off-screen column. At all other times, host accesses pass through unchanged.

Parameters:
MAP_COLS, 128, tilemap columns (power of 2); tilemap byte address = row*MAP_COLS + col
MAP_ROWS, 30, tile rows refilled per column
TILE_W_LOG2, 3, log2 of tile width in pixels; MAP_COLS << TILE_W_LOG2 must equal 1024
LEAD_COLS, 81, column distance ahead of the left screen column that is refilled
SCROLL_ADDR, 15'h3000, peripheral address of the scroll low byte; the high byte is at +1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  single-cycle pulse at the start of vertical blank
enable  in  1  scrolling enabled
speed  in  3  pixels added per frame (0..7)
host_chipselect  in  1  host Avalon request
host_write  in  1  host write (read when 0)
host_address  in  15  host address
host_writedata  in  8  host write data
host_readdata  out  8  read data returned to the host
host_waitrequest  out  1  host stalled
col_valid  in  1  column source has a tile byte available
col_data  in  8  tile number for the current row
col_ready  out  1  tile byte consumed this cycle
m_chipselect  out  1  to peripheral
m_write  out  1  to peripheral
m_address  out  15  to peripheral
m_writedata  out  8  to peripheral
m_readdata  in  8  from peripheral
scroll_offset  out  10  current committed pixel offset
busy  out  1  controller owns the bus
underrun  out  1  sticky: a frame_tick was dropped while busy

Behaviour:
- Reset values:
  - state IDLE; scroll_offset 0; row counter 0; fill column 0.
  - underrun 0; col_ready 0; busy 0; host_waitrequest 0.
  - m_* outputs follow the host signals, since the bus is granted to the host in IDLE.
- Reset asserted mid-sequence returns the FSM to IDLE immediately. Any partially written column stays as written.
- FSM states: IDLE, WR_LO, WR_HI, FILL.
- IDLE:
  - Bus mux selects the host: m_* = host_*, host_readdata = m_readdata, host_waitrequest = 0.
  - On frame_tick && enable:
    - Compute new = (scroll_offset + speed) mod 1024 and latch it.
    - crossed = (new >> TILE_W_LOG2) != (scroll_offset >> TILE_W_LOG2).
    - Go to WR_LO.
  - A host access in the same cycle as the tick completes normally that cycle. The controller takes the bus the next cycle.
  - frame_tick with enable=0 is ignored.
- WR_LO (1 cycle): write new[7:0] to SCROLL_ADDR. Go to WR_HI.
- WR_HI (1 cycle):
  - Write {6'b0, new[9:8]} to SCROLL_ADDR+1.
  - Update scroll_offset = new in this cycle.
  - If crossed:
    - fill_col = ((new >> TILE_W_LOG2) + LEAD_COLS) mod MAP_COLS.
    - row = 0.
    - Go to FILL.
  - Otherwise go to IDLE.
- FILL:
  - While col_valid: in the same cycle, issue one write with m_address = row*MAP_COLS + fill_col (bits 14:12 = 0), m_writedata = col_data, col_ready = 1, row++.
  - While !col_valid: m_chipselect = 0 and the FSM holds.
  - After the write for row MAP_ROWS-1, go to IDLE.
- busy = 1 in WR_LO, WR_HI and FILL. While busy:
  - m_* are driven by the controller.
  - host_waitrequest = 1 whenever host_chipselect = 1, and the host request is held off.
- frame_tick while busy is dropped and sets underrun. underrun clears only on reset.
- Speed is limited to 3 bits, so at most one column boundary is crossed per frame.
- scroll_offset wraps 1023 -> 0 modulo 1024. The column index wraps modulo MAP_COLS.
- Controller bus writes always have m_chipselect = m_write = 1. The peripheral accepts them in one cycle with no waitrequest.

Decomposition:
- Shared package gfx_pkg holds:
  - the state enum;
  - SCROLL_ADDR;
  - tilemap base and region constants;
  - MAP_COLS and MAP_ROWS defaults.
- The host/controller bus mux is the natural sub-module: avalon_bus_mux (select, two request bundles in, one out, readdata/waitrequest back). The FSM and address generation stay in tile_scroll_ctrl.

Test Plan:
- Reset, then enable=1, speed=3, one frame_tick -> writes 15'h3000<-8'h03 then 15'h3001<-8'h00 on consecutive cycles. scroll_offset=3. No FILL, busy low after 2 cycles.
- scroll_offset=6, speed=3, tick -> new=9, crossed -> scroll writes, then 30 writes to addresses row*128+82 (82, 210, ... 3794) with col_data 0..29. col_ready pulses 30 times.
- scroll_offset=1020, speed=7, tick -> new=3. Writes 8'h03 and 8'h00. fill_col=(0+81)=81.
- In FILL, hold col_valid low 5 cycles mid-column -> no m_chipselect and no row advance. Resumes at the same row address.
- Host write to 15'h0005 during FILL -> host_waitrequest=1 until IDLE, then the write appears on m_* in the same cycle waitrequest drops. A host read in IDLE returns m_readdata.
- Second frame_tick during FILL -> underrun=1 stays set. Frame ignored, scroll_offset unchanged by it. Async reset mid-FILL -> IDLE, busy=0, underrun=0.
